// File: rtl/gf2m_pkg.sv
// Shared types, curve constants and the one-bit shift-and-reduce helper
// used by the GF(2^m) digit-serial multiplier.
package gf2m_pkg;

  localparam int MAX_M = 571;

  localparam int SECT163K1_M = 163;
  localparam int SECT233K1_M = 233;
  localparam int SECT239K1_M = 239;
  localparam int SECT283K1_M = 283;
  localparam int SECT409K1_M = 409;
  localparam int SECT571K1_M = 571;
  localparam int DEFAULT_D   = 8;

  // Terms of f(x) below x^m, stored at the widest field size.
  localparam logic [MAX_M-1:0] SECT163K1_POLY = MAX_M'(8'hc9);
  localparam logic [MAX_M-1:0] SECT233K1_POLY = (MAX_M'(1) << 74) | MAX_M'(1);
  localparam logic [MAX_M-1:0] SECT239K1_POLY = (MAX_M'(1) << 158) | MAX_M'(1);
  localparam logic [MAX_M-1:0] SECT283K1_POLY = MAX_M'(13'h10a1);
  localparam logic [MAX_M-1:0] SECT409K1_POLY = (MAX_M'(1) << 87) | MAX_M'(1);
  localparam logic [MAX_M-1:0] SECT571K1_POLY = MAX_M'(11'h425);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // v*x mod f for an m-bit field; bits at and above m stay zero.
  function automatic logic [MAX_M-1:0] mulx_mod(input logic [MAX_M-1:0] v,
                                                input logic [MAX_M-1:0] poly,
                                                input int m);
    logic [MAX_M-1:0] r;
    logic [9:0]       top;
    logic             carry;
    r     = '0;
    top   = 10'(m - 1);
    carry = v[top];
    for (int i = 1; i < MAX_M; i++) begin
      if (i < m) r[i] = v[i-1];
    end
    if (carry) r = r ^ poly;
    return r;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One Horner iteration: next_acc = acc*x^D + a*digit, both reduced mod f.
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int             M    = 239,
  parameter int             D    = 8,
  parameter logic [M-1:0]   POLY = M'(SECT239K1_POLY)
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] next_acc
);

  logic [MAX_M-1:0] poly_ext;
  logic [MAX_M-1:0] shifted;
  logic [MAX_M-1:0] term;
  logic [MAX_M-1:0] sum;

  always_comb begin
    poly_ext = MAX_M'(POLY);
    shifted  = MAX_M'(acc);
    term     = MAX_M'(a);
    sum      = '0;
    for (int i = 0; i < D; i++) begin
      shifted = mulx_mod(shifted, poly_ext, M);
    end
    // term walks a*x^i so each digit bit selects an already-reduced partial.
    for (int i = 0; i < D; i++) begin
      if (digit[i]) sum = sum ^ term;
      term = mulx_mod(term, poly_ext, M);
    end
    next_acc = M'(shifted ^ sum);
  end

endmodule

// File: rtl/gf2m_ds_mul.sv
// Digit-serial GF(2^M) multiplier, MSB digit first, start/done/clr handshake.
// Handshake: start is a request sampled only in IDLE; done is a one-cycle pulse with z valid; z holds afterwards.
module gf2m_ds_mul
  import gf2m_pkg::*;
#(
  parameter int           M    = 239,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = M'(SECT239K1_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] z,
  output state_e       dbg_state
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   z_q, z_d;
  logic [M-1:0]   next_acc;
  logic [D-1:0]   digit;
  logic           last;

  // b is shifted left each iteration so the current digit is always on top.
  assign digit = b_q[W-1 -: D];
  assign last  = (cnt_q == CW'(N - 1));

  gf2m_digit_step #(
    .M    (M),
    .D    (D),
    .POLY (POLY)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .digit    (digit),
    .next_acc (next_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CALC;
        CALC:    if (last)  state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    z         = z_q;
    dbg_state = state_q;
  end

  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    z_d   = z_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      z_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d   = a;
            b_d   = W'(b);
            acc_d = '0;
            cnt_d = '0;
          end
        end
        CALC: begin
          acc_d = next_acc;
          cnt_d = cnt_q + CW'(1);
          b_d   = b_q << D;
          if (last) z_d = next_acc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      z_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
    end
  end

endmodule
